sdram_arbiter: RTL and testbench

Two-client request arbiter that sits directly upstream of the SDRAM controller core. It accepts single-word read and write requests from two independent masters, such as a CPU port and a video or DMA port. It serialises these requests onto the core's single control port and routes each completion pulse and its read data back to the client that issued it. A watchdog returns an error to the client if the core fails to complete a transaction.

---
 rtl/sdram_arbiter.sv | 140 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-client single-word request arbiter in front of the SDRAM controller core, with watchdog.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise client 0 has fixed priority.
module sdram_arbiter #(
   parameter int  DATA_WIDTH = 32,
   parameter int  ADDR_WIDTH = 24,
   parameter int  TIMEOUT    = 1024,
   localparam int BE_W       = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c0_rd,
   input  logic [BE_W-1:0]       c0_wr,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_wdata,
   output logic                  c0_rdy,
   output logic                  c0_rvalid,
   output logic                  c0_wvalid,
   output logic                  c0_error,
   output logic [DATA_WIDTH-1:0] c0_rdata,
   input  logic                  c1_rd,
   input  logic [BE_W-1:0]       c1_wr,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_wdata,
   output logic                  c1_rdy,
   output logic                  c1_rvalid,
   output logic                  c1_wvalid,
   output logic                  c1_error,
   output logic [DATA_WIDTH-1:0] c1_rdata,
   output logic                  core_rd,
   output logic [BE_W-1:0]       core_wr,
   output logic [ADDR_WIDTH-1:0] core_addr,
   output logic [DATA_WIDTH-1:0] core_wdata,
   input  logic                  core_rdy,
   input  logic                  core_rvalid,
   input  logic                  core_wvalid,
   input  logic [DATA_WIDTH-1:0] core_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

   state_t          state;
   logic            owner;
   logic            rd_lat;
   logic [BE_W-1:0] wr_lat;
   logic [15:0]     cnt;

   logic                  req0, req1, grant, accept, done, timeout;
   logic                  rsp_rv, rsp_wv;
   logic                  sel_rd;
   logic [BE_W-1:0]       sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   assign req0 = c0_rd | (|c0_wr);
   assign req1 = c1_rd | (|c1_wr);

`ifdef SDRAM_ARB_RR_EN
   logic last_served;
   assign grant = (req0 & req1) ? ~last_served : req1;
`else
   assign grant = ~req0 & req1;
`endif

   assign sel_rd    = grant ? c1_rd    : c0_rd;
   assign sel_wr    = grant ? c1_wr    : c0_wr;
   assign sel_addr  = grant ? c1_addr  : c0_addr;
   assign sel_wdata = grant ? c1_wdata : c0_wdata;

   assign accept  = (state == StIdle) & (req0 | req1);
   assign done    = (state == StWait) & (core_rvalid | core_wvalid);
   // A completion in the same cycle beats the watchdog.
   assign timeout = (state != StIdle) & ~done & (cnt == 16'(TIMEOUT - 1));

   // Responses are suppressed while rst is high so an abandoned transaction never reports.
   assign rsp_rv = ~rst & (done ? core_rvalid : (timeout & rd_lat));
   assign rsp_wv = ~rst & (done ? core_wvalid : (timeout & ~rd_lat));

   assign c0_rdy    = ~rst & (state == StIdle) & ~grant;
   assign c1_rdy    = ~rst & (state == StIdle) & grant;
   assign c0_rvalid = rsp_rv & ~owner;
   assign c1_rvalid = rsp_rv & owner;
   assign c0_wvalid = rsp_wv & ~owner;
   assign c1_wvalid = rsp_wv & owner;
   assign c0_error  = ~rst & timeout & ~owner;
   assign c1_error  = ~rst & timeout & owner;
   assign c0_rdata  = (c0_rvalid & done) ? core_rdata : '0;
   assign c1_rdata  = (c1_rvalid & done) ? core_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         owner      <= 1'b0;
         rd_lat     <= 1'b0;
         wr_lat     <= '0;
         cnt        <= '0;
         core_rd    <= 1'b0;
         core_wr    <= '0;
         core_addr  <= '0;
         core_wdata <= '0;
`ifdef SDRAM_ARB_RR_EN
         last_served <= 1'b1;
`endif
      end else begin
         case (state)
            StIdle: begin
               if (accept) begin
                  rd_lat     <= sel_rd;
                  wr_lat     <= sel_rd ? '0 : sel_wr;
                  core_rd    <= sel_rd;
                  core_wr    <= sel_rd ? '0 : sel_wr;
                  core_addr  <= sel_addr;
                  core_wdata <= sel_wdata;
                  owner      <= grant;
                  cnt        <= '0;
                  state      <= StIssue;
`ifdef SDRAM_ARB_RR_EN
                  last_served <= grant;
`endif
               end
            end
            StIssue: begin
               cnt <= cnt + 16'd1;
               if (timeout || core_rdy) begin
                  core_rd    <= 1'b0;
                  core_wr    <= '0;
                  core_addr  <= '0;
                  core_wdata <= '0;
                  state      <= timeout ? StIdle : StWait;
               end
            end
            StWait: begin
               cnt <= cnt + 16'd1;
               if (done || timeout) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: grant table, directed corner cases, and random
// traffic checked against a transaction-level model of the arbiter and a simple core.
module tb_sdram_arbiter;
   localparam int TO = 16;
`ifdef SDRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        c0_rd, c1_rd, c0_rdy, c1_rdy;
   logic [3:0]  c0_wr, c1_wr;
   logic [23:0] c0_addr, c1_addr;
   logic [31:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
   logic        c0_rvalid, c0_wvalid, c0_error, c1_rvalid, c1_wvalid, c1_error;
   logic        core_rd, core_rdy, core_rvalid, core_wvalid;
   logic [3:0]  core_wr;
   logic [23:0] core_addr;
   logic [31:0] core_wdata, core_rdata;

   sdram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(24), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_rdy(c0_rdy), .c0_rvalid(c0_rvalid), .c0_wvalid(c0_wvalid), .c0_error(c0_error),
      .c0_rdata(c0_rdata),
      .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_rdy(c1_rdy), .c1_rvalid(c1_rvalid), .c1_wvalid(c1_wvalid), .c1_error(c1_error),
      .c1_rdata(c1_rdata),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdy(core_rdy), .core_rvalid(core_rvalid), .core_wvalid(core_wvalid),
      .core_rdata(core_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [34:0] resp(input int n);
      return (n == 0) ? {c0_rvalid, c0_wvalid, c0_error, c0_rdata}
                      : {c1_rvalid, c1_wvalid, c1_error, c1_rdata};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
      return w;
   endfunction

   task automatic drop_reqs();
      c0_rd = 1'b0; c0_wr = 4'h0; c1_rd = 1'b0; c1_wr = 4'h0;
   endtask

   // Present a single request, expect it granted, leave the bench in the first ISSUE cycle.
   task automatic do_accept(input int n, input logic rd, input logic [3:0] wr,
                            input logic [23:0] a, input logic [31:0] d);
      if (n == 0) begin c0_rd = rd; c0_wr = wr; c0_addr = a; c0_wdata = d; end
      else begin c1_rd = rd; c1_wr = wr; c1_addr = a; c1_wdata = d; end
      @(negedge clk);
      chk("accept_rdy", 64'((n == 0) ? c0_rdy : c1_rdy), 64'(1));
      tick();
      drop_reqs();
   endtask

   // Core accepts now, completes next cycle; the response must reach client n only.
   task automatic finish_normal(input int n, input logic rd, input logic [31:0] data);
      core_rdy = 1'b1;
      tick();
      core_rdy = 1'b0;
      core_rvalid = rd;
      core_wvalid = !rd;
      core_rdata = data;
      @(negedge clk);
      chk("fin_owner", 64'(resp(n)), 64'({rd, !rd, 1'b0, rd ? data : 32'h0}));
      chk("fin_other", 64'(resp(1 - n)), 64'(0));
      tick();
      core_rvalid = 1'b0; core_wvalid = 1'b0; core_rdata = 32'h0;
      @(negedge clk);
      chk("fin_pulse_end", 64'(resp(n)), 64'(0));
      tick();
   endtask

   typedef struct {
      logic r0; logic [3:0] w0; logic r1; logic [3:0] w1; int win_rr; int win_fp;
   } vec_t;
   vec_t vecs[10];

   int          w, quiet, stable;
   logic        erd;
   logic [3:0]  ewr;
   logic [23:0] ea;
   logic [31:0] ed;

   // Random-phase state: clients, core model and reference model.
   logic        p_v[2], p_rd[2];
   logic [3:0]  p_wr[2];
   logic [23:0] p_addr[2];
   logic [31:0] p_wd[2];
   logic [31:0] cmem [logic [23:0]];
   logic [31:0] mmem [logic [23:0]];
   logic        c_pend, c_rd;
   logic [23:0] c_addr;
   int          c_dly, c_wait, kind, g;
   logic        m_busy, m_own, m_rd, m_took, m_last, r0, r1, done, to;
   logic [3:0]  m_be;
   logic [23:0] m_addr;
   logic [31:0] m_wd, edata;
   int          m_age;

   initial begin
      vecs[0] = '{1'b1, 4'h0, 1'b1, 4'h0, 0, 0};
      vecs[1] = '{1'b1, 4'h0, 1'b1, 4'h0, 1, 0};
      vecs[2] = '{1'b1, 4'h0, 1'b1, 4'h0, 0, 0};
      vecs[3] = '{1'b1, 4'h0, 1'b1, 4'h0, 1, 0};
      vecs[4] = '{1'b0, 4'hF, 1'b0, 4'h0, 0, 0};
      vecs[5] = '{1'b0, 4'h0, 1'b1, 4'h3, 1, 1};
      vecs[6] = '{1'b0, 4'h3, 1'b0, 4'hC, 0, 0};
      vecs[7] = '{1'b0, 4'h0, 1'b0, 4'h5, 1, 1};
      vecs[8] = '{1'b1, 4'h0, 1'b0, 4'hF, 0, 0};
      vecs[9] = '{1'b0, 4'h1, 1'b1, 4'h0, 1, 0};

      rst = 1'b1;
      drop_reqs();
      c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
      core_rdy = 1'b0; core_rvalid = 1'b0; core_wvalid = 1'b0; core_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_core", 64'({core_rd, core_wr, core_addr, core_wdata}), 64'(0));
      chk("reset_c0", 64'(resp(0)), 64'(0));
      chk("reset_c1", 64'(resp(1)), 64'(0));
      tick();

      // Grant table, starting from the reset arbitration state.
      for (int i = 0; i < 10; i++) begin
         w = RR ? vecs[i].win_rr : vecs[i].win_fp;
         c0_rd = vecs[i].r0; c0_wr = vecs[i].w0; c1_rd = vecs[i].r1; c1_wr = vecs[i].w1;
         c0_addr = 24'h000100 + 24'(i * 4);
         c1_addr = 24'h000200 + 24'(i * 4);
         c0_wdata = 32'h10000000 + i;
         c1_wdata = 32'h20000000 + i;
         erd = (w == 1) ? c1_rd : c0_rd;
         ewr = erd ? 4'h0 : ((w == 1) ? c1_wr : c0_wr);
         ea  = (w == 1) ? c1_addr : c0_addr;
         ed  = (w == 1) ? c1_wdata : c0_wdata;
         @(negedge clk);
         chk("vec_grant", 64'({c1_rdy, c0_rdy}), 64'((w == 1) ? 2'b10 : 2'b01));
         tick();
         drop_reqs();
         core_rdy = 1'b1;
         @(negedge clk);
         chk("vec_core_req", 64'({core_rd, core_wr, core_addr, core_wdata}), 64'({erd, ewr, ea, ed}));
         chk("vec_rdy_busy", 64'({c1_rdy, c0_rdy}), 64'(0));
         tick();
         core_rdy = 1'b0;
         core_rvalid = erd;
         core_wvalid = !erd;
         core_rdata = 32'hA5000000 + i;
         @(negedge clk);
         chk("vec_resp_owner", 64'(resp(w)), 64'({erd, !erd, 1'b0, erd ? 32'hA5000000 + i : 32'h0}));
         chk("vec_resp_other", 64'(resp(1 - w)), 64'(0));
         chk("vec_core_drop", 64'({core_rd, core_wr}), 64'(0));
         tick();
         core_rvalid = 1'b0; core_wvalid = 1'b0; core_rdata = '0;
      end

      // Write with a stalled core, then read back.
      do_accept(0, 1'b0, 4'hF, 24'h000100, 32'hDEADBEEF);
      stable = 1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         if (!(core_rd == 1'b0 && core_wr == 4'hF && core_addr == 24'h000100 &&
               core_wdata == 32'hDEADBEEF && resp(0) == '0)) stable = 0;
         tick();
      end
      chk("stall_stable", 64'(stable), 64'(1));
      finish_normal(0, 1'b0, 32'h0);
      do_accept(0, 1'b1, 4'h0, 24'h000100, 32'h0);
      @(negedge clk);
      chk("readback_req", 64'({core_rd, core_wr, core_addr}), 64'({1'b1, 4'h0, 24'h000100}));
      tick();
      finish_normal(0, 1'b1, 32'hDEADBEEF);

      // Read timeout after the core accepted; completion never arrives.
      do_accept(1, 1'b1, 4'h0, 24'h000300, 32'h0);
      core_rdy = 1'b1;
      core_rdata = 32'hBAD0BAD0;
      quiet = 1;
      for (int k = 0; k < TO - 1; k++) begin
         @(negedge clk);
         if (resp(0) != '0 || resp(1) != '0) quiet = 0;
         tick();
         core_rdy = 1'b0;
      end
      @(negedge clk);
      chk("to_rd_quiet", 64'(quiet), 64'(1));
      chk("to_rd_err", 64'(resp(1)), 64'({1'b1, 1'b0, 1'b1, 32'h0}));
      chk("to_rd_other", 64'(resp(0)), 64'(0));
      tick();
      core_rdata = '0;
      do_accept(0, 1'b1, 4'h0, 24'h000304, 32'h0);
      finish_normal(0, 1'b1, 32'h00000077);

      // Write timeout while the core never accepts.
      do_accept(0, 1'b0, 4'hF, 24'h000308, 32'h12121212);
      quiet = 1;
      for (int k = 0; k < TO - 1; k++) begin
         @(negedge clk);
         if (resp(0) != '0 || core_wr != 4'hF) quiet = 0;
         tick();
      end
      @(negedge clk);
      chk("to_wr_quiet", 64'(quiet), 64'(1));
      chk("to_wr_err", 64'(resp(0)), 64'({1'b0, 1'b1, 1'b1, 32'h0}));
      tick();
      @(negedge clk);
      chk("to_wr_drop", 64'({core_rd, core_wr, resp(0)}), 64'(0));
      tick();

      // Completion in the last watchdog cycle wins over the timeout.
      do_accept(0, 1'b1, 4'h0, 24'h00030C, 32'h0);
      core_rdy = 1'b1;
      tick();
      core_rdy = 1'b0;
      repeat (TO - 2) tick();
      core_rvalid = 1'b1;
      core_rdata = 32'h12345678;
      @(negedge clk);
      chk("to_race", 64'(resp(0)), 64'({1'b1, 1'b0, 1'b0, 32'h12345678}));
      tick();
      core_rvalid = 1'b0; core_rdata = '0;

      // Reset during WAIT abandons the transaction.
      do_accept(0, 1'b1, 4'h0, 24'h000310, 32'h0);
      core_rdy = 1'b1;
      tick();
      core_rdy = 1'b0;
      tick();
      rst = 1'b1;
      core_rvalid = 1'b1;
      core_rdata = 32'h55AA55AA;
      @(negedge clk);
      chk("rst_no_pulse", 64'({resp(0), resp(1)}), 64'(0));
      tick();
      rst = 1'b0;
      core_rvalid = 1'b0;
      core_rdata = '0;
      @(negedge clk);
      chk("rst_out_zero", 64'({core_rd, core_wr, core_addr, c0_rvalid, c1_rvalid,
                               c0_wvalid, c1_wvalid, c0_error, c1_error}), 64'(0));
      tick();
      do_accept(1, 1'b0, 4'h3, 24'h000314, 32'h0000BEEF);
      finish_normal(1, 1'b0, 32'h0);

      // Random traffic from both clients against a responsive core.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int n = 0; n < 2; n++) begin
         p_v[n] = 1'b0; p_rd[n] = 1'b0; p_wr[n] = 4'h0; p_addr[n] = '0; p_wd[n] = '0;
      end
      c_pend = 1'b0; c_rd = 1'b0; c_addr = '0; c_dly = 0; c_wait = 0;
      m_busy = 1'b0; m_own = 1'b0; m_rd = 1'b0; m_took = 1'b0; m_last = 1'b1;
      m_be = '0; m_addr = '0; m_wd = '0; m_age = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!p_v[n] && $urandom_range(9) < 4) begin
               kind = $urandom_range(3);
               p_v[n] = 1'b1;
               p_rd[n] = (kind == 0 || kind == 3);
               p_wr[n] = (kind >= 1) ? 4'($urandom_range(15, 1)) : 4'h0;
               p_addr[n] = 24'h000400 + 24'(4 * $urandom_range(7));
               p_wd[n] = $urandom;
            end
         end
         c0_rd = p_v[0] & p_rd[0]; c0_wr = p_v[0] ? p_wr[0] : 4'h0;
         c0_addr = p_addr[0]; c0_wdata = p_wd[0];
         c1_rd = p_v[1] & p_rd[1]; c1_wr = p_v[1] ? p_wr[1] : 4'h0;
         c1_addr = p_addr[1]; c1_wdata = p_wd[1];
         core_rvalid = 1'b0; core_wvalid = 1'b0; core_rdata = $urandom;
         if (c_pend) begin
            c_dly--;
            if (c_dly == 0) begin
               c_pend = 1'b0;
               if (c_rd) begin
                  core_rvalid = 1'b1;
                  core_rdata = cmem.exists(c_addr) ? cmem[c_addr] : 32'h0;
               end else core_wvalid = 1'b1;
            end
         end
         if (core_rd || core_wr != 4'h0) begin
            c_wait++;
            core_rdy = (c_wait >= 6) || ($urandom_range(1) == 1);
         end else begin
            c_wait = 0;
            core_rdy = ($urandom_range(3) == 0);
         end

         @(negedge clk);
         if (!m_busy) begin
            r0 = p_v[0]; r1 = p_v[1];
            g = (r0 && r1) ? ((RR && !m_last) ? 1 : 0) : (r1 ? 1 : 0);
            if (r0 || r1) chk("rnd_grant", 64'({c1_rdy, c0_rdy}), 64'((g == 1) ? 2'b10 : 2'b01));
            chk("rnd_idle_out", 64'({core_rd, core_wr, resp(0), resp(1)}), 64'(0));
            if (r0 || r1) begin
               m_busy = 1'b1; m_own = (g == 1); m_rd = p_rd[g];
               m_be = p_rd[g] ? 4'h0 : p_wr[g];
               m_addr = p_addr[g]; m_wd = p_wd[g];
               m_took = 1'b0; m_age = 0; m_last = (g == 1); p_v[g] = 1'b0;
            end
         end else begin
            chk("rnd_rdy_busy", 64'({c1_rdy, c0_rdy}), 64'(0));
            chk("rnd_core_req", 64'({core_rd, core_wr}), 64'(m_took ? 5'h0 : {m_rd, m_be}));
            if (!m_took)
               chk("rnd_core_aw", 64'({core_addr, core_wdata}), 64'({m_addr, m_wd}));
            done = m_took && (core_rvalid || core_wvalid);
            to = !done && (m_age == TO - 1);
            edata = (done && core_rvalid) ? (mmem.exists(m_addr) ? mmem[m_addr] : 32'h0) : 32'h0;
            chk("rnd_resp_owner", 64'(resp(int'(m_own))),
                64'({done ? core_rvalid : (to && m_rd), done ? core_wvalid : (to && !m_rd),
                     to, edata}));
            chk("rnd_resp_other", 64'(resp(int'(!m_own))), 64'(0));
            if (done && core_wvalid)
               mmem[m_addr] = merge(mmem.exists(m_addr) ? mmem[m_addr] : 32'h0, m_wd, m_be);
            if (!m_took && core_rdy) m_took = 1'b1;
            if (done || to) m_busy = 1'b0;
            else m_age++;
         end
         if ((core_rd || core_wr != 4'h0) && core_rdy) begin
            c_pend = 1'b1;
            c_dly = $urandom_range(4, 1);
            c_rd = core_rd;
            c_addr = core_addr;
            if (!core_rd)
               cmem[core_addr] = merge(cmem.exists(core_addr) ? cmem[core_addr] : 32'h0,
                                       core_wdata, core_wr);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
